// File: rtl/scan_disp_ctrl_if.sv
// Host/display bundle for the multiplexed 7-segment scan controller.
// The host side drives digit data and scan controls; the controller side drives the commons and segments.
interface scan_disp_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] din;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    load;
   logic                    lz_suppress;
   logic [3:0]              brightness;
   logic [NUM_DIGITS-1:0]   com;
   logic [6:0]              seg;
   logic                    dp;
   logic                    pending;
   logic                    frame_start;

   modport master (
      output din, dp_in, load, lz_suppress, brightness,
      input  com, seg, dp, pending, frame_start
   );

   modport slave (
      input  din, dp_in, load, lz_suppress, brightness,
      output com, seg, dp, pending, frame_start
   );
endinterface

// File: rtl/scan_disp_ctrl.sv
// Multiplexed 7-segment display scanner: prescaler -> 16-tick digit slots, PWM brightness,
// leading-zero blanking and a shadow/active double buffer swapped only at frame start.
module scan_disp_ctrl #(
   parameter int NUM_DIGITS     = 4,
   parameter int PRESCALE       = 64,
   parameter int COM_ACTIVE_LOW = 1,
   parameter int SEG_ACTIVE_LOW = 0
) (
   input logic            clk,
   input logic            rst_n,
   scan_disp_ctrl_if.slave bus
);
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = $clog2(NUM_DIGITS);
   localparam int DW = 4 * NUM_DIGITS;
   localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
   localparam logic [NUM_DIGITS-1:0] COM_OFF =
      (COM_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
   localparam logic [7:0] SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

   logic [PW-1:0]         presc;
   logic [3:0]            tick;
   logic [IW-1:0]         idx;
   logic [DW-1:0]         shadow, active;
   logic [NUM_DIGITS-1:0] shadow_dp, active_dp;
   logic                  pending_q, frame_start_q;
   logic [NUM_DIGITS-1:0] com_q;
   logic [6:0]            seg_q;
   logic                  dp_q;

   logic                  tick_en, frame_pt, xfer, com_on, suppress;
   logic [3:0]            digit;
   logic                  dig_zero, dp_sel, above;
   logic [NUM_DIGITS-1:0] zero_from, onehot;
   logic [6:0]            seg_nxt;

   function automatic logic [6:0] seg_decode(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h7E;  4'h1: s = 7'h30;  4'h2: s = 7'h6D;  4'h3: s = 7'h79;
         4'h4: s = 7'h33;  4'h5: s = 7'h5B;  4'h6: s = 7'h5F;  4'h7: s = 7'h70;
         4'h8: s = 7'h7F;  4'h9: s = 7'h73;  4'hA: s = 7'h41;  4'hB: s = 7'h09;
         4'hC: s = 7'h01;  4'hD: s = 7'h37;  4'hE: s = 7'h4F;  default: s = 7'h00;
      endcase
      return s;
   endfunction

   always_comb begin
      tick_en   = (presc == PS_LAST);
      frame_pt  = (idx == '0) && (tick == 4'd0) && (presc == '0);
      xfer      = frame_pt && pending_q;
      com_on    = (tick != 4'd0) && (tick <= bus.brightness);
      zero_from = '0;
      onehot    = '0;
      digit     = 4'h0;
      dig_zero  = 1'b0;
      dp_sel    = 1'b0;
      above     = 1'b1;
      // zero_from[i]: nibble i and every nibble above it are zero
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_from[i] = above && (active[4*i +: 4] == 4'h0);
         above        = zero_from[i];
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            digit     = active[4*i +: 4];
            dig_zero  = zero_from[i];
            dp_sel    = active_dp[i];
            onehot[i] = com_on;
         end
      end
      suppress = bus.lz_suppress && (idx != '0) && dig_zero;
      seg_nxt  = (com_on && !suppress) ? seg_decode(digit) : 7'h00;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc         <= '0;
         tick          <= 4'd0;
         idx           <= '0;
         shadow        <= '0;
         shadow_dp     <= '0;
         active        <= '0;
         active_dp     <= '0;
         pending_q     <= 1'b0;
         frame_start_q <= 1'b0;
         com_q         <= COM_OFF;
         seg_q         <= SEG_XOR[6:0];
         dp_q          <= SEG_XOR[7];
      end else begin
         presc <= tick_en ? '0 : presc + 1'b1;
         if (tick_en) begin
            tick <= tick + 4'd1;
            if (tick == 4'd15)
               idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end
         // swap happens while the blank tick 0 of digit 0 is on the pins
         if (xfer) begin
            active    <= shadow;
            active_dp <= shadow_dp;
         end
         if (bus.load) begin
            shadow    <= bus.din;
            shadow_dp <= bus.dp_in;
         end
         pending_q     <= bus.load | (pending_q & ~frame_pt);
         frame_start_q <= frame_pt;
         com_q         <= onehot ^ COM_OFF;
         seg_q         <= seg_nxt ^ SEG_XOR[6:0];
         dp_q          <= (com_on & dp_sel) ^ SEG_XOR[7];
      end
   end

   assign bus.com         = com_q;
   assign bus.seg         = seg_q;
   assign bus.dp          = dp_q;
   assign bus.pending     = pending_q;
   assign bus.frame_start = frame_start_q;

   a_com_onehot0 : assert property (@(posedge clk) $onehot0(onehot));
endmodule

// File: tb/tb_scan_disp_ctrl.sv
// Scoreboarded bench for scan_disp_ctrl (4 digits, prescale 1, active-low commons).
module tb_scan_disp_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   scan_disp_ctrl_if #(.NUM_DIGITS(4)) bus ();

   scan_disp_ctrl #(
      .NUM_DIGITS(4), .PRESCALE(1), .COM_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   logic [6:0] seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h73, 7'h41, 7'h09, 7'h01, 7'h37, 7'h4F, 7'h00};

   int n_vec = 0;
   int n_err = 0;

   // reference state: cycles since reset release and the two buffers
   int         m_t = 0;
   logic [15:0] m_sh = '0, m_act = '0;
   logic [3:0]  m_shdp = '0, m_actdp = '0;
   logic        m_pend = 1'b0;
   logic [13:0] exp_q [$];

   int         act_cnt [4];
   int         first_age [4];
   logic [6:0] last_seg [4];
   int         blank_cnt;
   int         fs_age = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic clr_stats();
      for (int d = 0; d < 4; d++) begin
         act_cnt[d]   = 0;
         first_age[d] = -1;
         last_seg[d]  = 7'h7F;
      end
      blank_cnt = 0;
   endtask

   task automatic cyc();
      logic [13:0] e;
      logic [13:0] got;
      logic [3:0]  cm, dig, pat;
      logic [6:0]  sg;
      logic        on, sup, dpx, fs;
      int          ph, slot, tk;
      if (!rst_n) begin
         e = {4'hF, 7'h00, 1'b0, 1'b0, 1'b0};
         m_t = 0; m_sh = '0; m_shdp = '0; m_act = '0; m_actdp = '0; m_pend = 1'b0;
      end else begin
         ph   = m_t % 64;
         slot = ph / 16;
         tk   = ph % 16;
         on   = (tk != 0) && (tk <= int'(bus.brightness));
         dig  = m_act[4*slot +: 4];
         sup  = bus.lz_suppress && (slot > 0) && ((m_act >> (4*slot)) == 16'h0);
         sg   = on ? (sup ? 7'h00 : seg_tbl[dig]) : 7'h00;
         dpx  = on ? m_actdp[slot] : 1'b0;
         cm   = on ? ~(4'b0001 << slot) : 4'hF;
         fs   = (ph == 0);
         if (fs && m_pend) begin
            m_act = m_sh; m_actdp = m_shdp;
         end
         if (bus.load) begin
            m_sh = bus.din; m_shdp = bus.dp_in;
         end
         m_pend = bus.load | (m_pend & !fs);
         e = {cm, sg, dpx, m_pend, fs};
         m_t++;
      end
      exp_q.push_back(e);
      @(posedge clk);
      @(negedge clk);
      got = {bus.com, bus.seg, bus.dp, bus.pending, bus.frame_start};
      chk("sb", 32'(got), 32'(exp_q.pop_front()));
      if (bus.frame_start) fs_age = 0; else fs_age++;
      if (bus.com == 4'hF) blank_cnt++;
      for (int d = 0; d < 4; d++) begin
         pat = ~(4'b0001 << d);
         if (bus.com == pat) begin
            act_cnt[d]++;
            last_seg[d] = bus.seg;
            if (first_age[d] < 0) first_age[d] = fs_age;
         end
      end
   endtask

   task automatic to_frame();
      while (m_t % 64 != 0) cyc();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      bus.din = 16'h1234; bus.dp_in = 4'hF; bus.load = 1'b1;
      bus.lz_suppress = 1'b0; bus.brightness = 4'd15;
      clr_stats();
      run(3);
      bus.load = 1'b0;
      chk("rst_com", 32'(bus.com), 32'hF);
      chk("rst_pend_load_ignored", 32'(bus.pending), 32'h0);

      // load coinciding with the first frame start after reset
      rst_n = 1'b1;
      bus.din = 16'h0F9A; bus.dp_in = 4'b0100; bus.load = 1'b1;
      cyc();
      bus.load = 1'b0;
      chk("first_fs", 32'(bus.frame_start), 32'h1);
      chk("first_pend", 32'(bus.pending), 32'h1);
      to_frame();

      // scan order and decode of 0F9A
      clr_stats();
      run(64);
      for (int d = 0; d < 4; d++) chk("scan_act15", 32'(act_cnt[d]), 32'd15);
      chk("scan_blank4", 32'(blank_cnt), 32'd4);
      chk("dec_d0", 32'(last_seg[0]), 32'h41);
      chk("dec_d1", 32'(last_seg[1]), 32'h73);
      chk("dec_d2", 32'(last_seg[2]), 32'h00);
      chk("dec_d3", 32'(last_seg[3]), 32'h7E);
      chk("pend_clear", 32'(bus.pending), 32'h0);

      // mid-frame load: old data stays until the next frame
      run(10);
      bus.din = 16'h0050; bus.dp_in = 4'b0000; bus.load = 1'b1; bus.lz_suppress = 1'b1;
      cyc();
      bus.load = 1'b0;
      chk("mid_pend", 32'(bus.pending), 32'h1);
      clr_stats();
      to_frame();
      chk("old_d1_shown", 32'(last_seg[1]), 32'h73);
      chk("old_pend_held", 32'(bus.pending), 32'h1);

      // load on the frame-start cycle while pending: 0050 goes active, 2222 waits
      bus.din = 16'h2222; bus.load = 1'b1;
      clr_stats();
      cyc();
      bus.load = 1'b0;
      chk("coinc_fs", 32'(bus.frame_start), 32'h1);
      chk("coinc_pend", 32'(bus.pending), 32'h1);
      run(63);
      chk("lz_d0", 32'(last_seg[0]), 32'h7E);
      chk("lz_d1", 32'(last_seg[1]), 32'h5B);
      chk("lz_d2", 32'(last_seg[2]), 32'h00);
      chk("lz_d3", 32'(last_seg[3]), 32'h00);
      cyc();
      chk("coinc_pend_clear", 32'(bus.pending), 32'h0);
      to_frame();

      // brightness 0 and 4
      bus.brightness = 4'd0;
      clr_stats();
      run(64);
      for (int d = 0; d < 4; d++) chk("bri0_act", 32'(act_cnt[d]), 32'd0);
      chk("bri0_blank", 32'(blank_cnt), 32'd64);
      bus.brightness = 4'd4;
      clr_stats();
      run(64);
      for (int d = 0; d < 4; d++) chk("bri4_act", 32'(act_cnt[d]), 32'd4);
      chk("bri4_start_tick1", 32'(first_age[0]), 32'd1);

      // reset while digit 2 is being shown with data pending
      bus.brightness = 4'd15;
      run(20);
      bus.din = 16'h1234; bus.load = 1'b1;
      cyc();
      bus.load = 1'b0;
      while (m_t % 64 != 40) cyc();
      rst_n = 1'b0;
      cyc();
      chk("mid_rst_com", 32'(bus.com), 32'hF);
      chk("mid_rst_pend", 32'(bus.pending), 32'h0);
      rst_n = 1'b1;
      clr_stats();
      cyc();
      chk("post_rst_fs", 32'(bus.frame_start), 32'h1);
      run(15);
      chk("post_rst_d0", 32'(act_cnt[0]), 32'd15);
      chk("post_rst_d2", 32'(act_cnt[2]), 32'd0);
      chk("post_rst_seg0", 32'(last_seg[0]), 32'h7E);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/scan_disp_ctrl.md
SCAN_DISP_CTRL -- requirements
Module: scan_disp_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4, is the number of multiplexed digits; legal range 2..8.
REQ-002 Parameter PRESCALE, default 64, is the number of clk cycles per tick; legal range 1..65535.
REQ-003 Parameter COM_ACTIVE_LOW, default 1: when 1 the selected common drives 0, otherwise 1.
REQ-004 Parameter SEG_ACTIVE_LOW, default 0: when 1, seg and dp are inverted at the output.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 din  in  4*NUM_DIGITS  BCD/hex nibbles; nibble i (bits 4i+3:4i) is digit i, and digit 0 is least significant.
REQ-008 dp_in  in  NUM_DIGITS  decimal point per digit.
REQ-009 load  in  1  single-cycle strobe that captures din/dp_in into the shadow buffer.
REQ-010 lz_suppress  in  1  enables leading-zero blanking.
REQ-011 brightness  in  4  on-ticks per digit slot; 0 = dark, 15 = maximum.
REQ-012 com  out  NUM_DIGITS  digit common drives.
REQ-013 seg  out  7  segments a..g; bit6 = a, bit0 = g.
REQ-014 dp  out  1  decimal point segment.
REQ-015 pending  out  1  shadow holds data not yet shown.
REQ-016 frame_start  out  1  one-cycle pulse at the start of digit 0 slot.

Function
REQ-017 The prescaler counts 0..PRESCALE-1 and issues one tick enable on the cycle it equals PRESCALE-1, then wraps to 0.
REQ-018 The tick counter (4 bits) advances on each tick and wraps 15->0; each digit slot lasts 16 ticks.
REQ-019 The digit index advances when the tick counter wraps and goes 0,1,..,NUM_DIGITS-1,0; no other sequence is permitted.
REQ-020 Tick 0 of every slot is a blanking tick: all com inactive, for ghost suppression.
REQ-021 The selected common com[idx] is active during ticks 1..brightness and inactive otherwise; brightness is sampled every cycle.
REQ-022 Exactly one com bit is active at a time, or none; a one-hot violation is a design error.
REQ-023 Segment encoding (hex, active-high, a..g) is 0:7E 1:30 2:6D 3:79 4:33 5:5B 6:5F 7:70 8:7F 9:73 A:41 B:09 C:01 D:37 E:4F F:00.
REQ-024 Leading-zero suppression: when lz_suppress=1, digit i>0 shows seg=00 if its nibble and every nibble above it are 0; dp is unaffected; digit 0 is never suppressed.
REQ-025 When load=1, the shadow buffer takes din/dp_in on that edge and pending is set to 1.
REQ-026 Transfer occurs on the cycle frame_start is asserted: if pending=1, the active buffer takes the shadow and pending clears.
REQ-027 When load and a transfer occur in the same cycle, the active buffer takes the old shadow, the shadow takes the new din, and pending remains 1.
REQ-028 The active buffer never changes mid-frame, so no torn display is possible.
REQ-029 com, seg and dp are registered and reflect the counter state of the previous cycle (1-cycle latency).
REQ-030 seg and dp are driven only while a common is active; otherwise they are 00/0 before polarity inversion.
REQ-031 frame_start asserts the cycle the digit index becomes 0 with the tick counter at 0.

Reset
REQ-032 When rst_n=0 at a clk edge, all of the following clear: prescaler, tick counter, digit index, shadow buffer, active buffer, pending, and frame_start.
REQ-033 During and after reset, com drives all-inactive (all 1 if COM_ACTIVE_LOW=1), and seg/dp drive their inactive level.
REQ-034 Reset asserted mid-frame aborts the frame and discards pending data; the first frame_start occurs one cycle after rst_n rises.
REQ-035 load is ignored while rst_n=0.

Verification
REQ-036 Scan order: NUM_DIGITS=4, PRESCALE=1, brightness=15 -> com (active-low) cycles 1110,1101,1011,0111 with 15 active cycles per 16-cycle slot, plus a 1-cycle all-1111 blank between slots.
REQ-037 Decode: din=16'h0F9A, lz_suppress=0 -> digit 0 seg=41, digit 1 seg=73, digit 2 seg=00, digit 3 seg=7E.
REQ-038 Leading-zero suppression: din=16'h0050, lz_suppress=1 -> digits 3 and 2 seg=00, digit 1 seg=5B, digit 0 seg=7E.
REQ-039 Double buffer: load mid-frame -> pending=1 and old data is shown until the next frame_start, then new data appears and pending=0; load coinciding with frame_start -> pending stays 1.
REQ-040 Brightness: brightness=0 -> com never active; brightness=4 -> exactly 4 active ticks per slot, starting at tick 1.
REQ-041 Reset mid-frame: rst_n=0 for 1 cycle at digit 2 -> com all-inactive, pending=0, and the next frame begins at digit 0.
